// File: rtl/sgpio_shift_ctrl.sv
// rtl/sgpio_shift_ctrl.sv - SGPIO serial shift controller: one N-bit word out on sg_dout, one in from sg_din per frame
// Optional feature macro SGPIO_CTRL_LOOPBACK_EN: rx sampler takes sg_dout instead of sg_din.
module sgpio_shift_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic         abort,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy,
  output logic         sg_clk,
  output logic         sg_en_n,
  output logic         sg_dout,
  input  logic         sg_din
);

  localparam int CW = $clog2(N);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  div_cnt, div_cnt_nx;
  logic [CW-1:0]  bit_cnt, bit_cnt_nx;
  logic [N-1:0]   shadow, shadow_nx;
  logic [N-1:0]   rx_sr, rx_sr_nx;
  logic           div_last;
  logic           sample_bit;

`ifdef SGPIO_CTRL_LOOPBACK_EN
  assign sample_bit = sg_dout;
`else
  assign sample_bit = sg_din;
`endif

  assign div_last = (div_cnt == DW'(DIV - 1));

  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    bit_cnt_nx = bit_cnt;
    shadow_nx  = shadow;
    rx_sr_nx   = rx_sr;
    case (state)
      IDLE: begin
        // tx_ready is low on the first cycle after reset, so no acceptance there
        if (!abort && tx_valid && tx_ready) begin
          shadow_nx  = tx_data;
          bit_cnt_nx = '0;
          div_cnt_nx = '0;
          state_nx   = LO;
        end
      end
      LO: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (div_last) begin
          rx_sr_nx   = {sample_bit, rx_sr[N-1:1]};
          div_cnt_nx = '0;
          state_nx   = HI;
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end
      HI: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (div_last) begin
          div_cnt_nx = '0;
          shadow_nx  = shadow >> 1;
          bit_cnt_nx = bit_cnt + CW'(1);
          state_nx   = (bit_cnt == CW'(N - 1)) ? DONE : LO;
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shadow   <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      sg_clk   <= 1'b0;
      sg_en_n  <= 1'b1;
      sg_dout  <= 1'b0;
    end else begin
      state    <= state_nx;
      div_cnt  <= div_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shadow   <= shadow_nx;
      rx_sr    <= rx_sr_nx;
      tx_ready <= (state_nx == IDLE);
      busy     <= (state_nx != IDLE);
      sg_clk   <= (state_nx == HI);
      sg_en_n  <= !((state_nx == LO) || (state_nx == HI));
      rx_valid <= (state_nx == DONE);
      if (state_nx == DONE) rx_data <= rx_sr_nx;
      // Data only moves on LO entry: DIV cycles of setup before each sg_clk rise
      if ((state_nx == LO) && (state != LO)) sg_dout <= shadow_nx[0];
    end
  end

endmodule

// File: tb/tb_sgpio_shift_ctrl.sv
// tb/tb_sgpio_shift_ctrl.sv - directed self-checking bench for sgpio_shift_ctrl with an external shift-register model
module tb_sgpio_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       abort;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sg_clk;
  logic       sg_en_n;
  logic       sg_dout;
  logic       sg_din;

  logic [7:0] model;
  logic [7:0] model_init;
  logic       model_load;
  logic       din_zero;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  sgpio_shift_ctrl #(.N(8), .DIV(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .abort   (abort),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .sg_clk  (sg_clk),
    .sg_en_n (sg_en_n),
    .sg_dout (sg_dout),
    .sg_din  (sg_din)
  );

  always #5 clk = ~clk;

  always @(posedge sg_clk or posedge model_load) begin
    if (model_load) model <= model_init;
    else if (!sg_en_n) model <= {sg_dout, model[7:1]};
  end

  assign sg_din = din_zero ? 1'b0 : model[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] sent, input logic [7:0] reg_before);
`ifdef SGPIO_CTRL_LOOPBACK_EN
    exp_rx = sent;
`else
    exp_rx = reg_before;
`endif
  endfunction

  // Returns at the sampling point of the rx_valid cycle (or after the cycle budget).
  task automatic run_frame(input logic [7:0] d, input bit pulse, input bit hold,
                           output int lat, output logic [7:0] bits);
    lat  = -1;
    bits = '0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    check("accept_ready", tx_ready, 1);
    @(posedge clk);
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) tx_valid = 1'b0;
      if (pulse && i == 2) begin
        check("hi_ready_low", tx_ready, 0);
        check("hi_sg_clk", sg_clk, 1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
      end
      if (pulse && i == 3) tx_valid = 1'b0;
      if (i < 32 && (i % 4) == 0) bits[i/4] = sg_dout;
      if (rx_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  int         lat;
  int         pulses;
  logic [7:0] bits;
  logic [7:0] last_rx;

  initial begin
    rst_n      = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    abort      = 1'b0;
    din_zero   = 1'b0;
    model_init = 8'h00;
    model_load = 1'b1;
    #1 model_load = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_sg_en_n", sg_en_n, 1);
    check("rst_sg_clk", sg_clk, 0);
    check("rst_sg_dout", sg_dout, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tx_ready", tx_ready, 1);

    // Register preloaded with 0x3C, send 0xA5
    model_init = 8'h3C;
    model_load = 1'b1;
    #1 model_load = 1'b0;
    run_frame(8'hA5, 1'b0, 1'b0, lat, bits);
    check("a5_latency", lat, 32);
    check("a5_dout_bits", bits, 8'hA5);
    check("a5_rx_data", rx_data, exp_rx(8'hA5, 8'h3C));
    check("a5_model", model, 8'hA5);
    check("done_sg_en_n", sg_en_n, 1);
    check("done_sg_clk", sg_clk, 0);
    check("done_busy", busy, 1);
    check("done_tx_ready", tx_ready, 0);
    @(negedge clk);
    check("rx_valid_pulse", rx_valid, 0);
    check("idle_busy", busy, 0);
    check("rx_data_hold", rx_data, exp_rx(8'hA5, 8'h3C));

    // Back-to-back with tx_valid held: 0x01 then 0x80
    run_frame(8'h01, 1'b0, 1'b1, lat, bits);
    check("b2b1_latency", lat, 32);
    check("b2b1_rx_data", rx_data, exp_rx(8'h01, 8'hA5));
    tx_data = 8'h80;
    @(negedge clk);
    check("b2b_idle_ready", tx_ready, 1);
    check("b2b_idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b2_accepted", tx_ready, 0);
    check("b2b2_first_bit", sg_dout, 0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        lat = i;
        break;
      end
    end
    check("b2b2_latency", lat, 32);
    check("b2b2_rx_data", rx_data, exp_rx(8'h80, 8'h01));

    // tx_valid pulse with 0xFF during HI must be ignored
    run_frame(8'h33, 1'b1, 1'b0, lat, bits);
    check("ign_latency", lat, 32);
    check("ign_dout_bits", bits, 8'h33);
    check("ign_rx_data", rx_data, exp_rx(8'h33, 8'h80));
    check("ign_model", model, 8'h33);

    // sg_din tied low, send 0x5A
    din_zero = 1'b1;
    run_frame(8'h5A, 1'b0, 1'b0, lat, bits);
    check("din0_latency", lat, 32);
    check("din0_rx_data", rx_data, exp_rx(8'h5A, 8'h00));
    last_rx  = exp_rx(8'h5A, 8'h00);
    din_zero = 1'b0;

    // Abort 10 cycles into a frame
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_sg_en_n", sg_en_n, 1);
    check("abort_sg_clk", sg_clk, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    check("abort_tx_ready", tx_ready, 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid) pulses++;
    end
    check("abort_no_rx_valid", pulses, 0);
    check("abort_rx_data", rx_data, last_rx);

    // abort wins over tx_valid in IDLE
    @(negedge clk);
    abort    = 1'b1;
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    tx_valid = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_sg_en_n", sg_en_n, 1);

    // Asynchronous reset mid-frame
    @(negedge clk);
    tx_data  = 8'hE7;
    tx_valid = 1'b1;
    @(posedge clk);
    repeat (6) @(negedge clk);
    tx_valid = 1'b0;
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sg_en_n", sg_en_n, 1);
    check("arst_sg_clk", sg_clk, 0);
    check("arst_rx_valid", rx_valid, 0);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_busy", busy, 0);
    check("arst_tx_ready", tx_ready, 0);
    @(negedge clk);
    check("arst_hold_ready", tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_ready", tx_ready, 1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_valid) pulses++;
    end
    check("arst_no_rx_valid", pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sgpio_shift_ctrl.md
SGPIO_SHIFT_CTRL -- requirements
Module: sgpio_shift_ctrl

Interface
REQ-001 Parameter N, default 8: shift-register length and word width in bits, N >= 2.
REQ-002 Parameter DIV, default 2: sg_clk half-period in clk cycles, DIV >= 1.
REQ-003 clk  in  1  single system clock (SB_HFOSC output); all logic on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 tx_data  in  N  word to shift out, LSB first.
REQ-006 tx_valid  in  1  tx_data valid.
REQ-007 tx_ready  out  1  controller accepts a word this cycle.
REQ-008 abort  in  1  synchronous frame abort.
REQ-009 rx_data  out  N  word captured from sg_din.
REQ-010 rx_valid  out  1  one-cycle pulse, rx_data valid.
REQ-011 busy  out  1  frame in progress.
REQ-012 sg_clk  out  1  shift clock to the external shift register.
REQ-013 sg_en_n  out  1  active-low shift enable; low only while framing.
REQ-014 sg_dout  out  1  serial bit to the register input.
REQ-015 sg_din  in  1  serial bit from the register output (bit 0).

Function
REQ-016 States IDLE, LO, HI, DONE; all outputs registered.
REQ-017 IDLE: tx_ready=1, busy=0, sg_en_n=1, sg_clk=0; tx_valid&tx_ready latches tx_data into a shadow register, clears bit counter, enters LO.
REQ-018 LO: sg_clk=0, sg_en_n=0, sg_dout=shadow[0]; lasts exactly DIV cycles, then HI.
REQ-019 In the last LO cycle, sg_din is shifted into the rx register at the MSB (right shift), so the first sampled bit ends in rx_data[0].
REQ-020 HI: sg_clk=1, sg_en_n=0; lasts DIV cycles; on exit, shadow shifts right one bit, counter increments; counter==N-1 on exit -> DONE, else -> LO.
REQ-021 sg_dout changes only on the LO entry cycle, giving DIV cycles of setup before each sg_clk rising edge.
REQ-022 DONE: one cycle, sg_en_n=1, sg_clk=0, rx_valid=1, rx_data updated; next state IDLE.
REQ-023 rx_valid asserts exactly 2*DIV*N cycles after the accepting edge; rx_data holds until the next DONE.
REQ-024 tx_ready=0 in LO/HI/DONE; tx_valid outside IDLE is ignored and not queued.
REQ-025 Back-to-back: with tx_valid held, next acceptance occurs on the IDLE cycle following DONE (one idle cycle between frames).
REQ-026 abort in LO/HI/DONE: next state IDLE, sg_en_n=1, sg_clk=0, no rx_valid, rx_data unchanged.
REQ-027 abort with tx_valid in IDLE: abort wins, no acceptance.
REQ-028 busy=1 in LO, HI, DONE.

Reset
REQ-029 rst_n low: immediately IDLE, sg_clk=0, sg_en_n=1, sg_dout=0, tx_ready=0 while asserted, rx_valid=0, busy=0, rx_data=0, shadow=0, counter=0.
REQ-030 Reset mid-frame discards the frame; no rx_valid after release; tx_ready=1 on the first clk edge after release.

Configuration
REQ-031 Macro SGPIO_CTRL_LOOPBACK_EN: when defined, the rx sampler takes sg_dout instead of sg_din, so rx_data equals the tx_data of the same frame; sg_din is unused.
REQ-032 Without SGPIO_CTRL_LOOPBACK_EN, sampling uses sg_din per REQ-019; all other behaviour is identical.

Verification (N=8, DIV=2, behavioural 8-bit right-shift register on sg_clk rising edge, load when sg_en_n=0)
REQ-033 Reset: assert rst_n mid-run -> sg_en_n=1, sg_clk=0, rx_valid=0, rx_data=0x00 with no clk edge.
REQ-034 Model preloaded 0x3C, send 0xA5 -> sg_dout 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid 32 cycles after acceptance; model holds 0xA5.
REQ-035 tx_valid held with 0x01 then 0x80 -> second acceptance exactly 1 cycle after first rx_valid; rx_data second frame = 0x01.
REQ-036 abort 10 cycles into a frame -> next cycle sg_en_n=1, sg_clk=0, no rx_valid, tx_ready=1 the cycle after.
REQ-037 tx_valid pulsed during HI with 0xFF -> ignored; frame completes with original data.
REQ-038 SGPIO_CTRL_LOOPBACK_EN defined, sg_din tied 0, send 0x5A -> rx_data=0x5A.
